frame_pixel_streamer: RTL and testbench

- Raster pixel source that reads an 8-bit grayscale frame from a synchronous single-port frame RAM.
- Emits the frame in row-major order as a `write`-qualified pixel stream into the 3x3 window line buffer that feeds the Sobel stage.
- It is the hardware transmitter for the buffer's pixel input and replaces the bench-driven raster feeder.
- Adds frame/line markers and start/done control for the pipeline controller.

---
 rtl/frame_pixel_streamer.sv | 179 +++++++++++++++++
 tb/tb_frame_pixel_streamer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
// Raster pixel source for the 3x3 window line buffer. It reads an 8-bit
// grayscale frame from a synchronous single-port RAM in row-major order and
// forwards each pixel as a write-qualified stream. Frame and line markers
// travel with every pixel, and start/busy/done handshake with the pipeline
// controller.
//
// Pipeline:
//   issue stage  : (state == STREAM && !stall) -> mem_rd_en, mem_addr.
//                  The read is tagged with first/last_col.
//   output stage : one cycle later the RAM data is valid. write, frame_start
//                  and line_end come from the registered tags, and out_pixel
//                  forwards mem_rdata.
//
// With stall low throughout, a start accepted in cycle 0 gives the first
// write in cycle 2. The last write is followed by done one cycle later.

module frame_pixel_streamer #(
    parameter int WIDTH  = 508,
    parameter int HEIGHT = 508,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        out_pixel,
    output logic              write,
    output logic              frame_start,
    output logic              line_end,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Raster position of the next read and its running RAM address.
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] addr_q;

    // Output-stage registers. These hold the tags of the read issued last cycle.
    logic              write_q;
    logic              frame_start_q;
    logic              line_end_q;
    logic [7:0]        pixel_hold_q;

    // Issue-stage decodes.
    logic issue;
    logic at_col_last;
    logic at_row_last;
    logic at_first;
    logic last_issue;

    assign at_col_last = (col_q == COL_LAST);
    assign at_row_last = (row_q == ROW_LAST);
    assign at_first    = (col_q == '0) && (row_q == '0);
    assign last_issue  = issue && at_col_last && at_row_last;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is honoured only in IDLE, and rst overrides it.
    always_comb begin
        // NOTE: default first, so no path through this block leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start)      state_d = STREAM;
            STREAM: if (last_issue) state_d = DRAIN;
            DRAIN:                  state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output decode. A read is issued on every unstalled STREAM cycle.
    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE:   ;
            STREAM: begin
                issue = !stall;
                busy  = 1'b1;
            end
            DRAIN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_rd_en = issue;
    assign mem_addr  = addr_q;

    // Raster counters and address incrementer. They advance only on an issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (state_q == IDLE && start) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (issue) begin
            if (at_col_last) begin
                col_q <= '0;
                if (at_row_last) begin
                    // Frame finished: park at (0,0) so counters never pass the edge.
                    row_q  <= '0;
                    addr_q <= '0;
                end else begin
                    row_q  <= row_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
            end else begin
                col_q  <= col_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    // Output stage. Tags are registered from the issue cycle, and rst drops
    // the in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q       <= 1'b0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            pixel_hold_q  <= '0;
        end else begin
            write_q       <= issue;
            frame_start_q <= issue && at_first;
            line_end_q    <= issue && at_col_last;
            if (write_q) begin
                pixel_hold_q <= mem_rdata;
            end
        end
    end

    // The RAM output register already supplies the one-cycle latency.
    // Forwarding mem_rdata keeps the first write 2 cycles after start.
    // pixel_hold_q keeps the last pixel stable between writes.
    assign out_pixel   = write_q ? mem_rdata : pixel_hold_q;
    assign write       = write_q;
    assign frame_start = frame_start_q;
    assign line_end    = line_end_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed bench for frame_pixel_streamer on a 4x3 frame with RAM[i] = i.
// Each check has its expected value written out from the cycle plan.
// The plan covers unstalled streaming, a 3-cycle stall, start ignored while
// busy, start+rst together, and reset in mid-frame followed by a restart.

module tb_frame_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stall;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic [7:0]    out_pixel;
    logic          write;
    logic          frame_start;
    logic          line_end;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:(1<<AW)-1];

    frame_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .out_pixel   (out_pixel),
        .write       (write),
        .frame_start (frame_start),
        .line_end    (line_end),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Synchronous frame RAM: data is valid in the cycle after mem_rd_en.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle. Inputs are driven 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The expected write window is cycles 2..last_wr, minus the gap gap_lo..gap_hi.
    function automatic bit wr_exp(int c, int last_wr, int gap_lo, int gap_hi);
        return (c >= 2) && (c <= last_wr) && !((c >= gap_lo) && (c <= gap_hi));
    endfunction

    // One frame. start is driven in cycle 0, and stall is high in cycles
    // st_lo..st_hi. start is pulsed again in cycle again_c, which must be ignored.
    task automatic run_frame(input int st_lo, input int st_hi, input int again_c,
                             input int last_wr, input int gap_lo, input int gap_hi,
                             input string name);
        int idx;
        bit we;
        idx = 0;
        step();
        start = 1'b1;
        stall = 1'b0;
        #1;
        chk({name, ".c0_rd_en"}, mem_rd_en, 1'b0);
        chk({name, ".c0_busy"},  busy,      1'b0);
        for (int c = 1; c <= last_wr + 2; c++) begin
            step();
            start = (c == again_c);
            stall = (c >= st_lo) && (c <= st_hi);
            #1;
            we = wr_exp(c, last_wr, gap_lo, gap_hi);
            chk($sformatf("%s.write@%0d", name, c), write, we);
            chk($sformatf("%s.fs@%0d", name, c), frame_start, we && (idx == 0));
            chk($sformatf("%s.le@%0d", name, c), line_end, we && ((idx % W) == W - 1));
            if (we) begin
                chk($sformatf("%s.pix@%0d", name, c), out_pixel, idx);
                idx++;
            end
            chk($sformatf("%s.busy@%0d", name, c), busy, c <= last_wr + 1);
            chk($sformatf("%s.done@%0d", name, c), done, c == last_wr + 1);
            if (wr_exp(c + 1, last_wr, gap_lo, gap_hi)) begin
                chk($sformatf("%s.rd_en@%0d", name, c), mem_rd_en, 1'b1);
                chk($sformatf("%s.addr@%0d", name, c), mem_addr, idx);
            end else begin
                chk($sformatf("%s.rd_en@%0d", name, c), mem_rd_en, 1'b0);
            end
        end
        start = 1'b0;
        stall = 1'b0;
        chk({name, ".pixel_count"}, idx, W * H);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i);
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state.
        chk("rst.mem_addr",    mem_addr,    '0);
        chk("rst.mem_rd_en",   mem_rd_en,   1'b0);
        chk("rst.out_pixel",   out_pixel,   8'h00);
        chk("rst.write",       write,       1'b0);
        chk("rst.frame_start", frame_start, 1'b0);
        chk("rst.line_end",    line_end,    1'b0);
        chk("rst.busy",        busy,        1'b0);
        chk("rst.done",        done,        1'b0);

        // Unstalled frame: writes in cycles 2..13, done in cycle 14.
        run_frame(-1, -1, -1, 13, -1, -1, "plain");

        // Stall in cycles 4..6 with start pulsed in cycle 6 while busy.
        // Pixel 2 still appears in cycle 4, there are no writes in cycles
        // 5..7, the last write is in cycle 16 and done is in cycle 17.
        run_frame(4, 6, 6, 16, 5, 7, "stall");

        // A second start after done streams the identical frame from 0x00.
        run_frame(-1, -1, -1, 13, -1, -1, "again");

        // start and rst in the same cycle: rst wins.
        step();
        start = 1'b1;
        rst   = 1'b1;
        #1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        #1;
        chk("start_rst.busy",  busy,      1'b0);
        chk("start_rst.rd_en", mem_rd_en, 1'b0);
        step();
        chk("start_rst.busy2", busy,      1'b0);
        chk("start_rst.write", write,     1'b0);

        // rst in cycle 7 of a frame. Pixels 0..5 are written in cycles 2..7.
        step();
        start = 1'b1;
        #1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            rst   = (c == 7);
            #1;
            chk($sformatf("midrst.write@%0d", c), write, c >= 2);
            if (c >= 2) chk($sformatf("midrst.pix@%0d", c), out_pixel, c - 2);
        end
        step();
        rst = 1'b0;
        #1;
        chk("midrst.c8_write",    write,       1'b0);
        chk("midrst.c8_busy",     busy,        1'b0);
        chk("midrst.c8_addr",     mem_addr,    '0);
        chk("midrst.c8_rd_en",    mem_rd_en,   1'b0);
        chk("midrst.c8_pix",      out_pixel,   8'h00);
        chk("midrst.c8_fs",       frame_start, 1'b0);
        step();
        chk("midrst.c9_write",    write,       1'b0);

        // Restart after the reset: streams again from 0x00 with frame_start.
        run_frame(-1, -1, -1, 13, -1, -1, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
